// File: rtl/lb_ctrl_pkg.sv
// Shared types and helpers for the line-buffer window sequencer.
// Holds FSM state encoding and the array's "no capture" pointer code.
package lb_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN,
    ERR
  } state_t;

  localparam logic [2:0] INIT_HOLD = 3'd7;

  function automatic int unsigned min_k(
    input int unsigned col_cnt,
    input int unsigned k
  );
    return (col_cnt < k - 1) ? col_cnt : k - 1;
  endfunction

endpackage

// File: rtl/lb_col_counter.sv
// Column / slot / band position tracker for the window sequencer.
// Advances on accepted beats; wraps column and slot at end of band.
module lb_col_counter
  import lb_ctrl_pkg::*;
#(
  parameter int KER_SIZE = 3,
  parameter int AW       = 8,
  parameter int PTRW     = 3
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            clr,
  input  logic            beat,
  input  logic [AW-1:0]   cfg_w,
  input  logic [AW-1:0]   cfg_h,
  output logic [AW-1:0]   col_cnt,
  output logic [AW-1:0]   band,
  output logic [PTRW-1:0] slot,
  output logic            last_col,
  output logic            last_band
);

  localparam logic [PTRW-1:0] SLOT_MAX = PTRW'(KER_SIZE - 1);

  assign last_col  = (col_cnt == cfg_w - AW'(1));
  assign last_band = (band == cfg_h - AW'(KER_SIZE));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_cnt <= '0;
      band    <= '0;
      slot    <= '0;
    end else if (clr) begin
      col_cnt <= '0;
      band    <= '0;
      slot    <= '0;
    end else if (beat) begin
      if (last_col) begin
        col_cnt <= '0;
        slot    <= '0;
        band    <= band + AW'(1);
      end else begin
        col_cnt <= col_cnt + AW'(1);
        slot    <= (slot == SLOT_MAX) ? '0
                 : slot + PTRW'(1);
      end
    end
  end

endmodule

// File: rtl/line_buffer_seq_ctrl.sv
// Sequencer for the KxK line-buffer window array: drives slot pointers,
// tracks window validity/coordinates and both valid/ready handshakes.
module line_buffer_seq_ctrl
  import lb_ctrl_pkg::*;
#(
  parameter int KER_SIZE = 3,
  parameter int AW       = 8,
  parameter int PTRW     = 3
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic [AW-1:0]   cfg_w,
  input  logic [AW-1:0]   cfg_h,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [PTRW-1:0] col_ptr,
  output logic [PTRW-1:0] init_col_ptr,
  output logic            win_valid,
  input  logic            win_ready,
  output logic [AW-1:0]   win_x,
  output logic [AW-1:0]   win_y,
  output logic            busy,
  output logic            done,
  output logic            cfg_err
);

  state_t          state;
  state_t          state_n;
  logic [AW-1:0]   w_q;
  logic [AW-1:0]   h_q;
  logic [AW-1:0]   col_cnt;
  logic [AW-1:0]   band;
  logic [PTRW-1:0] slot;
  logic            last_col;
  logic            last_band;
  logic            beat;
  logic            capture;
  logic            launch;
  logic            cfg_ok;

  assign cfg_ok = (cfg_w >= AW'(KER_SIZE))
               && (cfg_h >= AW'(KER_SIZE));
  assign launch = (state == IDLE) && start;

  assign in_ready = (state == RUN)
                 && (!win_valid || win_ready);
  assign beat     = in_valid && in_ready;
  assign capture  = beat
                 && (col_cnt >= AW'(KER_SIZE - 1));
  assign busy     = (state == RUN) || (state == FIN);
  assign col_ptr  = slot;

  // Off-beat code never matches K-1, so the array holds its output.
  assign init_col_ptr = beat
    ? PTRW'(min_k(32'(col_cnt), KER_SIZE))
    : PTRW'(INIT_HOLD);

  lb_col_counter #(
    .KER_SIZE (KER_SIZE),
    .AW       (AW),
    .PTRW     (PTRW)
  ) u_cnt (
    .clk       (clk),
    .rstn      (rstn),
    .clr       (launch),
    .beat      (beat),
    .cfg_w     (w_q),
    .cfg_h     (h_q),
    .col_cnt   (col_cnt),
    .band      (band),
    .slot      (slot),
    .last_col  (last_col),
    .last_band (last_band)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      w_q   <= '0;
      h_q   <= '0;
    end else begin
      state <= state_n;
      if (launch) begin
        w_q <= cfg_w;
        h_q <= cfg_h;
      end
    end
  end

  always_comb begin
    state_n = state;
    done    = 1'b0;
    cfg_err = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_n = cfg_ok ? RUN : ERR;
      end
      RUN: begin
        if (beat && last_col && last_band)
          state_n = FIN;
      end
      FIN: begin
        if (!win_valid) begin
          state_n = IDLE;
          done    = 1'b1;
        end
      end
      ERR: begin
        state_n = IDLE;
        cfg_err = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      win_valid <= 1'b0;
      win_x     <= '0;
      win_y     <= '0;
    end else if (capture) begin
      win_valid <= 1'b1;
      win_x     <= col_cnt - AW'(KER_SIZE - 1);
      win_y     <= band;
    end else if (win_ready) begin
      win_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_line_buffer_seq_ctrl.sv
// Directed bench for line_buffer_seq_ctrl (K=3 and K=5 instances).
// Checks pointers, window order/coords, stalls, errors and resets.
module tb_line_buffer_seq_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start3;
  logic       start5;
  logic [7:0] cfg_w;
  logic [7:0] cfg_h;
  logic       in_valid;
  logic       win_ready;
  logic       sel5;

  logic       ir3, wv3, bz3, dn3, ce3;
  logic [2:0] cp3, icp3;
  logic [7:0] wx3, wy3;
  logic       ir5, wv5, bz5, dn5, ce5;
  logic [2:0] cp5, icp5;
  logic [7:0] wx5, wy5;

  logic       ir, wv, bz, dn, ce;
  logic [2:0] cp, icp;
  logic [7:0] wx, wy;

  int checks = 0;
  int errors = 0;

  int cp_e3[10]  = '{0, 1, 2, 0, 1, 0, 1, 2, 0, 1};
  int icp_e3[10] = '{0, 1, 2, 2, 2, 0, 1, 2, 2, 2};
  int wx_e3[6]   = '{0, 1, 2, 0, 1, 2};
  int wy_e3[6]   = '{0, 0, 0, 1, 1, 1};
  int cp_e5[5]   = '{0, 1, 2, 3, 4};

  always #5 clk = ~clk;

  line_buffer_seq_ctrl #(
    .KER_SIZE (3), .AW (8), .PTRW (3)
  ) u3 (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start3),
    .cfg_w        (cfg_w),
    .cfg_h        (cfg_h),
    .in_valid     (in_valid),
    .in_ready     (ir3),
    .col_ptr      (cp3),
    .init_col_ptr (icp3),
    .win_valid    (wv3),
    .win_ready    (win_ready),
    .win_x        (wx3),
    .win_y        (wy3),
    .busy         (bz3),
    .done         (dn3),
    .cfg_err      (ce3)
  );

  line_buffer_seq_ctrl #(
    .KER_SIZE (5), .AW (8), .PTRW (3)
  ) u5 (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start5),
    .cfg_w        (cfg_w),
    .cfg_h        (cfg_h),
    .in_valid     (in_valid),
    .in_ready     (ir5),
    .col_ptr      (cp5),
    .init_col_ptr (icp5),
    .win_valid    (wv5),
    .win_ready    (win_ready),
    .win_x        (wx5),
    .win_y        (wy5),
    .busy         (bz5),
    .done         (dn5),
    .cfg_err      (ce5)
  );

  assign ir  = sel5 ? ir5  : ir3;
  assign wv  = sel5 ? wv5  : wv3;
  assign bz  = sel5 ? bz5  : bz3;
  assign dn  = sel5 ? dn5  : dn3;
  assign ce  = sel5 ? ce5  : ce3;
  assign cp  = sel5 ? cp5  : cp3;
  assign icp = sel5 ? icp5 : icp3;
  assign wx  = sel5 ? wx5  : wx3;
  assign wy  = sel5 ? wy5  : wy3;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rst(input string p);
    chk({p, "_cp"},   32'(cp),  0);
    chk({p, "_icp"},  32'(icp), 7);
    chk({p, "_ir"},   32'(ir),  0);
    chk({p, "_wv"},   32'(wv),  0);
    chk({p, "_wx"},   32'(wx),  0);
    chk({p, "_wy"},   32'(wy),  0);
    chk({p, "_busy"}, 32'(bz),  0);
    chk({p, "_done"}, 32'(dn),  0);
    chk({p, "_err"},  32'(ce),  0);
  endtask

  task automatic do_start(
    input bit k5,
    input int w,
    input int h
  );
    sel5   = k5;
    cfg_w  = 8'(w);
    cfg_h  = 8'(h);
    start3 = !k5;
    start5 = k5;
    tick();
    start3 = 1'b0;
    start5 = 1'b0;
    // Scrambled config mid-run must be ignored.
    cfg_w  = 8'd1;
    cfg_h  = 8'd200;
    chk("start_busy", 32'(bz), 1);
  endtask

  task automatic run(
    input string p,
    input bit    k5,
    input bit    tog,
    input int    stall,
    input int    nbeat,
    input int    nwin
  );
    int beats  = 0;
    int wins   = 0;
    int dones  = 0;
    int cyc    = 0;
    int st     = 0;
    int last_c = -10;
    int done_c = -20;
    int e_cp;
    int e_icp;
    while (dones == 0 && cyc < 400) begin
      in_valid = tog ? (cyc % 2 == 0) : 1'b1;
      if (stall > 0 && wv && st < stall) begin
        win_ready = 1'b0;
        st++;
      end else begin
        win_ready = 1'b1;
      end
      #1;
      if (!win_ready) begin
        chk({p, "_stall_ir"},  32'(ir),  0);
        chk({p, "_stall_icp"}, 32'(icp), 7);
        chk({p, "_stall_cp"},  32'(cp),  0);
        chk({p, "_stall_wx"},  32'(wx),  0);
        chk({p, "_stall_wy"},  32'(wy),  0);
      end
      if (in_valid && ir) begin
        if (beats < nbeat) begin
          e_cp  = k5 ? cp_e5[beats] : cp_e3[beats];
          e_icp = k5 ? cp_e5[beats] : icp_e3[beats];
          chk({p, "_cp"},  32'(cp),  32'(e_cp));
          chk({p, "_icp"}, 32'(icp), 32'(e_icp));
        end
        beats++;
      end else if (bz) begin
        chk({p, "_idle_icp"}, 32'(icp), 7);
      end
      if (wv && win_ready) begin
        if (wins < nwin) begin
          chk({p, "_wx"}, 32'(wx), k5 ? 0 : wx_e3[wins]);
          chk({p, "_wy"}, 32'(wy), k5 ? 0 : wy_e3[wins]);
        end
        wins++;
        last_c = cyc;
      end
      if (dn) begin
        dones++;
        done_c = cyc;
      end
      tick();
      cyc++;
    end
    chk({p, "_beats"},   32'(beats), 32'(nbeat));
    chk({p, "_wins"},    32'(wins),  32'(nwin));
    chk({p, "_dones"},   32'(dones), 1);
    chk({p, "_done_at"}, 32'(done_c), 32'(last_c + 1));
    chk({p, "_idle"},    32'(bz), 0);
  endtask

  initial begin
    rstn      = 1'b0;
    start3    = 1'b0;
    start5    = 1'b0;
    cfg_w     = 8'd0;
    cfg_h     = 8'd0;
    in_valid  = 1'b0;
    win_ready = 1'b0;
    sel5      = 1'b0;
    tick();
    chk_rst("rst3");
    sel5 = 1'b1;
    chk_rst("rst5");
    sel5 = 1'b0;
    tick();
    rstn = 1'b1;
    tick();

    do_start(0, 5, 4);
    run("base", 0, 0, 0, 10, 6);
    tick();

    do_start(0, 5, 4);
    run("stall", 0, 0, 4, 10, 6);
    tick();

    do_start(0, 5, 4);
    run("tog", 0, 1, 0, 10, 6);
    tick();

    sel5      = 1'b0;
    cfg_w     = 8'd2;
    cfg_h     = 8'd4;
    in_valid  = 1'b1;
    win_ready = 1'b1;
    start3    = 1'b1;
    tick();
    start3 = 1'b0;
    chk("err_pulse", 32'(ce), 1);
    chk("err_busy",  32'(bz), 0);
    chk("err_ir",    32'(ir), 0);
    tick();
    chk("err_clear", 32'(ce), 0);
    chk("err_busy2", 32'(bz), 0);
    chk("err_ir2",   32'(ir), 0);
    tick();

    do_start(0, 5, 4);
    in_valid  = 1'b1;
    win_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("pre_rst_wv", 32'(wv), 1);
    rstn = 1'b0;
    #1;
    chk_rst("midrst");
    tick();
    chk("midrst_done", 32'(dn), 0);
    rstn = 1'b1;
    tick();
    do_start(0, 5, 4);
    run("rerun", 0, 0, 0, 10, 6);
    tick();

    do_start(1, 5, 5);
    run("k5", 1, 0, 0, 5, 1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_buffer_seq_ctrl.md
Name: line_buffer_seq_ctrl

Overview:
- Sequencer for the KxK line-buffer window array (k2/k3/k5 variants).
- Accepts a stream of K-pixel vertical columns for an image of cfg_w x cfg_h. Drives the array's col_ptr and init_col_ptr.
- Flags when the array's registered pixel_out holds a valid window, tagged with its output coordinates.
- Owns upstream/downstream valid/ready handshakes. Sits between the column fetch unit and the PE array.

Parameters:
- KER_SIZE, 3, kernel size K; legal 2..5.
- AW, 8, width of image dimension and coordinate fields.
- PTRW, 3, width of col_ptr/init_col_ptr (matches array ports).

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- start  in  1  1-cycle pulse; latches config and begins frame when IDLE; ignored otherwise.
- cfg_w  in  AW  image width in columns.
- cfg_h  in  AW  image height in rows.
- in_valid  in  1  upstream column beat valid.
- in_ready  out  1  controller accepts beat; beat = in_valid & in_ready.
- col_ptr  out  PTRW  array slot written this cycle.
- init_col_ptr  out  PTRW  array fill level / capture strobe.
- win_valid  out  1  array pixel_out holds an unconsumed window.
- win_ready  in  1  downstream consumes window.
- win_x  out  AW  output column of current window.
- win_y  out  AW  output row (band) of current window.
- busy  out  1  frame in progress.
- done  out  1  1-cycle pulse at frame end.
- cfg_err  out  1  1-cycle pulse, illegal config at start.

Behaviour:
- Reset values:
  - col_ptr=0, init_col_ptr=7, in_ready=0, win_valid=0, win_x=0, win_y=0, busy=0, done=0, cfg_err=0. State IDLE; all counters 0.
  - Reset mid-frame aborts immediately; no done pulse.
- States:
  - IDLE -> RUN on start with cfg_w>=K and cfg_h>=K.
  - IDLE -> ERR on start otherwise.
  - ERR -> IDLE after 1 cycle, cfg_err=1 during ERR.
  - RUN -> FIN on the beat completing the last column of the last band.
  - FIN -> IDLE when win_valid==0 (last window consumed). done=1 on the FIN->IDLE cycle.
  - busy=1 in RUN and FIN.
- Counters:
  - col_cnt: column within band, 0..cfg_w-1.
  - slot: col_cnt mod K, wraps K-1->0.
  - band: 0..cfg_h-K.
  - On beat: col_cnt++, slot++ (wrap). At col_cnt==cfg_w-1: col_cnt=0, slot=0, band++.
- col_ptr = slot, combinational from registered state, stable while stalled. The array slot at col_ptr is scratch (excluded from the next window), so continuous capture during stall is harmless.
- init_col_ptr:
  - Equals min(col_cnt, K-1) only on a beat cycle; otherwise forced to 7.
  - 7 never equals K-1, so the array output flop captures only on accepted beats.
- in_ready = (state==RUN) & (~win_valid | win_ready).
- Window capture:
  - Beat with col_cnt>=K-1 makes the array capture at that edge. win_valid rises the next cycle (latency 1 from beat) with win_x=col_cnt-(K-1), win_y=band.
  - win_valid clears on win_ready unless a new capture occurs in the same cycle (then it stays 1 with updated coordinates).
- Per band: cfg_w-K+1 windows; first K-1 beats of each band produce none. Total windows = (cfg_w-K+1)*(cfg_h-K+1).
- Config is latched at start; changes to cfg_* during RUN are ignored.
- Stride 1 only; no padding.

Decomposition:
- Package lb_ctrl_pkg:
  - state enum {IDLE, RUN, FIN, ERR}.
  - INIT_HOLD=3'd7 constant.
  - function min_k(col_cnt, K).
- One sub-module: lb_col_counter (col_cnt/slot/band with wrap and last flags).
- FSM and handshake stay in the top.

Test Plan:
- K=3, cfg_w=5, cfg_h=4, in_valid=1, win_ready=1 -> 10 beats; col_ptr 0,1,2,0,1 per band; init_col_ptr 0,1,2,2,2 on beats. 6 win_valid pulses with (x,y)=(0,0),(1,0),(2,0),(0,1),(1,1),(2,1); done 1 cycle after last window consumed.
- Same config, win_ready held 0 after first window -> in_ready=0; init_col_ptr=7; col_ptr frozen; win_x/win_y hold (0,0). Release -> sequence resumes with no window lost or duplicated.
- in_valid toggling every other cycle -> init_col_ptr=7 on idle cycles; window count and order identical to first case.
- start with cfg_w=2, K=3 -> cfg_err pulse 1 cycle, busy stays 0, no in_ready.
- rstn asserted at beat 4 of first case -> all outputs at reset values; new start re-runs the full 6-window sequence correctly.
- K=5, cfg_w=5, cfg_h=5 -> single window (0,0) after beat 5; init_col_ptr 0..4; done follows.
